// File: rtl/mux_n_pipe_if.sv
// Stream bundle for mux_n_pipe: upstream select/data handshake and registered downstream output.
// oSelErr exists only when MUX_N_PIPE_SEL_ERR_EN is defined.
interface mux_n_pipe_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NUM   = 3,
    parameter int unsigned SEL_W = 2
);
    logic [NUM*WIDTH-1:0] iData;
    logic [SEL_W-1:0]     iS;
    logic                 iValid;
    logic                 oReady;
    logic [WIDTH-1:0]     oData;
    logic                 oValid;
    logic                 iReady;
`ifdef MUX_N_PIPE_SEL_ERR_EN
    logic                 oSelErr;
`endif

    modport slave (
        input  iData, iS, iValid, iReady,
`ifdef MUX_N_PIPE_SEL_ERR_EN
        output oSelErr,
`endif
        output oReady, oData, oValid
    );

    modport master (
        output iData, iS, iValid, iReady,
`ifdef MUX_N_PIPE_SEL_ERR_EN
        input  oSelErr,
`endif
        input  oReady, oData, oValid
    );
endinterface

// File: rtl/mux_n_pipe.sv
// N-way W-bit selector with registered output and one-entry skid buffer (valid/ready, full throughput).
// Optional sticky out-of-range select flag oSelErr under MUX_N_PIPE_SEL_ERR_EN.
module mux_n_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NUM   = 3,
    parameter int unsigned SEL_W = 2
) (
    input logic         clk,
    input logic         rst,
    mux_n_pipe_if.slave bus
);

    if (NUM < 2 || NUM > 16) begin : g_num_chk
        $error("mux_n_pipe: NUM=%0d outside 2..16", NUM);
    end
    if ((2 ** SEL_W) < NUM) begin : g_sel_chk
        $error("mux_n_pipe: SEL_W=%0d too narrow for NUM=%0d", SEL_W, NUM);
    end

    logic [WIDTH-1:0] w_sel_word;
    logic             w_in_xfer;
    logic             w_out_free;
    logic             w_ready;

    logic [WIDTH-1:0] r_out;
    logic             r_out_v;
    logic [WIDTH-1:0] r_skid;
    logic             r_skid_v;

    // Out-of-range selects fall through to the last input.
    always_comb begin
        w_sel_word = bus.iData[(NUM-1)*WIDTH +: WIDTH];
        for (int unsigned k = 0; k < NUM; k++) begin
            if (bus.iS == SEL_W'(k)) begin
                w_sel_word = bus.iData[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_ready    = ~r_skid_v & ~rst;
    assign w_in_xfer  = bus.iValid & w_ready;
    assign w_out_free = ~r_out_v | bus.iReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out    <= '0;
            r_out_v  <= 1'b0;
            r_skid   <= '0;
            r_skid_v <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_v) begin
                r_out    <= r_skid;
                r_out_v  <= 1'b1;
                r_skid_v <= 1'b0;
            end else if (w_in_xfer) begin
                r_out    <= w_sel_word;
                r_out_v  <= 1'b1;
            end else begin
                r_out_v  <= 1'b0;
            end
        end else if (w_in_xfer) begin
            r_skid   <= w_sel_word;
            r_skid_v <= 1'b1;
        end
    end

    assign bus.oReady = w_ready;
    assign bus.oData  = r_out;
    assign bus.oValid = r_out_v;

`ifdef MUX_N_PIPE_SEL_ERR_EN
    if (NUM == (2 ** SEL_W)) begin : g_selerr_tie
        assign bus.oSelErr = 1'b0;
    end else begin : g_selerr
        logic w_sel_oor;
        logic r_sel_err;

        assign w_sel_oor = (32'(bus.iS) >= NUM);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sel_err <= 1'b0;
            end else if (w_in_xfer && w_sel_oor) begin
                r_sel_err <= 1'b1;
            end
        end

        assign bus.oSelErr = r_sel_err;
    end
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed checks on a 3x32 instance plus scoreboard-driven random stress on a 5x8 instance.
// oSelErr checks compile in only when MUX_N_PIPE_SEL_ERR_EN is defined.
module tb_mux_n_pipe;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [7:0] q[$];
    bit         err_m;
    bit         hold;
    logic [7:0] prev_d;

    always #5 clk = ~clk;

    mux_n_pipe_if #(.WIDTH(32), .NUM(3), .SEL_W(2)) u_a ();
    mux_n_pipe_if #(.WIDTH(8),  .NUM(5), .SEL_W(3)) u_b ();

    mux_n_pipe #(.WIDTH(32), .NUM(3), .SEL_W(2)) u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (u_a)
    );

    mux_n_pipe #(.WIDTH(8), .NUM(5), .SEL_W(3)) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (u_b)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] sel5(input logic [39:0] d, input logic [2:0] s);
        int unsigned idx;
        idx = (s >= 3'd5) ? 4 : int'(s);
        return d[idx*8 +: 8];
    endfunction

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        u_a.iValid = 1'b1;
        u_a.iReady = 1'b1;
        u_a.iS     = 2'd0;
        u_a.iData  = {32'h33333333, 32'h22222222, 32'h11111111};
        u_b.iValid = 1'b0;
        u_b.iReady = 1'b1;
        u_b.iS     = '0;
        u_b.iData  = '0;

        // Reset held two cycles with iValid=1
        tick();
        tick();
        chk("rst_oready", u_a.oReady, 0);
        chk("rst_ovalid", u_a.oValid, 0);
        chk("rst_odata",  u_a.oData,  0);
`ifdef MUX_N_PIPE_SEL_ERR_EN
        chk("rst_selerr", u_a.oSelErr, 0);
`endif
        rst_a = 1'b0;
        u_a.iValid = 1'b0;
        #1;
        chk("rel_oready", u_a.oReady, 1);
        chk("rel_ovalid", u_a.oValid, 0);

        // Basic back-to-back selection
        u_a.iValid = 1'b1;
        u_a.iS = 2'd0;
        tick();
        chk("sel0_valid", u_a.oValid, 1);
        chk("sel0_data",  u_a.oData,  32'h11111111);
        u_a.iS = 2'd1;
        tick();
        chk("sel1_data",  u_a.oData,  32'h22222222);
        u_a.iS = 2'd2;
        tick();
        chk("sel2_data",  u_a.oData,  32'h33333333);
        chk("sel2_valid", u_a.oValid, 1);
`ifdef MUX_N_PIPE_SEL_ERR_EN
        chk("sel2_selerr", u_a.oSelErr, 0);
`endif

        // Out-of-range select defaults to last input
        u_a.iS = 2'd3;
        u_a.iData = {32'hDEADBEEF, 32'h22222222, 32'h11111111};
        tick();
        chk("oor_data", u_a.oData, 32'hDEADBEEF);
`ifdef MUX_N_PIPE_SEL_ERR_EN
        chk("oor_selerr", u_a.oSelErr, 1);
`endif
        u_a.iValid = 1'b0;
        tick();
        chk("idle_valid", u_a.oValid, 0);
        chk("idle_hold",  u_a.oData,  32'hDEADBEEF);

        // Back-pressure: A to OUT, B to SKID, C held upstream
        u_a.iS = 2'd0;
        u_a.iValid = 1'b1;
        u_a.iData = {32'h0, 32'h0, 32'hA};
        tick();
        chk("bp_a_data", u_a.oData, 32'hA);
        u_a.iReady = 1'b0;
        u_a.iData = {32'h0, 32'h0, 32'hB};
        tick();
        chk("bp_a_hold",    u_a.oData,  32'hA);
        chk("bp_a_valid",   u_a.oValid, 1);
        chk("bp_skid_full", u_a.oReady, 0);
        u_a.iData = {32'h0, 32'h0, 32'hC};
        tick();
        chk("bp_a_hold2", u_a.oData,  32'hA);
        chk("bp_c_held",  u_a.oReady, 0);
        u_a.iReady = 1'b1;
        tick();
        chk("bp_b_data",  u_a.oData,  32'hB);
        chk("bp_b_valid", u_a.oValid, 1);
        chk("bp_ready",   u_a.oReady, 1);
        tick();
        chk("bp_c_data",  u_a.oData,  32'hC);
        chk("bp_c_valid", u_a.oValid, 1);
        u_a.iValid = 1'b0;
        tick();
        chk("bp_drained", u_a.oValid, 0);
`ifdef MUX_N_PIPE_SEL_ERR_EN
        chk("selerr_sticky", u_a.oSelErr, 1);
`endif

        // Reset with OUT and SKID both full
        u_a.iValid = 1'b1;
        u_a.iData = {32'h0, 32'h0, 32'h55};
        tick();
        u_a.iReady = 1'b0;
        u_a.iData = {32'h0, 32'h0, 32'h66};
        tick();
        chk("mr_skid_full", u_a.oReady, 0);
        rst_a = 1'b1;
        tick();
        chk("mr_ovalid", u_a.oValid, 0);
        chk("mr_odata",  u_a.oData,  0);
        rst_a = 1'b0;
        u_a.iValid = 1'b0;
        u_a.iReady = 1'b1;
        #1;
        chk("mr_oready", u_a.oReady, 1);
        tick();
        chk("mr_no_ghost_v", u_a.oValid, 0);
        chk("mr_no_ghost_d", u_a.oData,  0);
`ifdef MUX_N_PIPE_SEL_ERR_EN
        chk("mr_selerr", u_a.oSelErr, 0);
`endif

        // Random stress on NUM=5, WIDTH=8
        rst_b = 1'b0;
        err_m = 1'b0;
        hold  = 1'b0;
        prev_d = '0;
        tick();
        for (int c = 0; c < 2000; c++) begin
            chk("st_valid", u_b.oValid, 64'(q.size() != 0));
            chk("st_ready", u_b.oReady, 64'(q.size() < 2));
            if (hold) begin
                chk("st_hold", u_b.oData, prev_d);
            end
`ifdef MUX_N_PIPE_SEL_ERR_EN
            chk("st_selerr", u_b.oSelErr, err_m);
`endif
            u_b.iValid = 1'($urandom_range(0, 1));
            u_b.iReady = ($urandom_range(0, 3) != 0);
            u_b.iS     = 3'($urandom_range(0, 7));
            u_b.iData  = 40'({$urandom(), $urandom()});
            #1;
            hold   = u_b.oValid && !u_b.iReady;
            prev_d = u_b.oData;
            if (u_b.oValid && u_b.iReady && q.size() != 0) begin
                chk("st_order", u_b.oData, q[0]);
                void'(q.pop_front());
            end
            if (u_b.iValid && u_b.oReady) begin
                q.push_back(sel5(u_b.iData, u_b.iS));
                if (u_b.iS >= 3'd5) err_m = 1'b1;
            end
            tick();
        end

        u_b.iValid = 1'b0;
        u_b.iReady = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (u_b.oValid && q.size() != 0) begin
                chk("drain_order", u_b.oData, q[0]);
                void'(q.pop_front());
            end
            tick();
        end
        chk("drain_empty", 64'(q.size()), 0);
        chk("drain_valid", u_b.oValid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
